// File: rtl/mands_frame_tx.sv
// MandS stream transmitter: FIFO-buffered signed samples sent as start + valid-qualified frames.
// Optional build macro MANDS_TX_GAP_EN inserts one idle cycle between consecutive samples.
module mands_frame_tx #(
    parameter int DEPTH     = 16,
    parameter int LEN_W     = 5,
    parameter int MAX_FRAME = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           wr_en,
    input  logic [7:0]                     wr_data,
    output logic                           full,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    input  logic                           send,
    input  logic [LEN_W-1:0]               frame_len,
    output logic                           busy,
    output logic                           done,
    output logic                           start,
    output logic                           valid,
    output logic [7:0]                     data
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

`ifdef MANDS_TX_GAP_EN
    localparam bit GAP_EN = 1'b1;
`else
    localparam bit GAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, START, STREAM, DONE} state_t;

    logic [7:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              start_q, start_d;
    logic              valid_q, valid_d;
    logic [7:0]        data_q, data_d;
    logic              gap_q, gap_d;
    logic              push, pop, full_w, empty_w;

    assign full_w  = (count_q == CNT_W'(DEPTH));
    assign empty_w = (count_q == '0);

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        start_d = 1'b0;
        valid_d = 1'b0;
        data_d  = 8'h00;
        gap_d   = 1'b0;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (send) begin
                    state_d = START;
                    busy_d  = 1'b1;
                    start_d = 1'b1;
                    rem_d   = (frame_len > LEN_W'(MAX_FRAME)) ? LEN_W'(MAX_FRAME) : frame_len;
                end
            end
            START, STREAM: begin
                // Outputs are registered, so the first pop is issued while start is showing.
                if (rem_q == '0) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = STREAM;
                    if (!gap_q && !empty_w) begin
                        pop     = 1'b1;
                        valid_d = 1'b1;
                        data_d  = mem[rd_ptr_q];
                        rem_d   = rem_q - LEN_W'(1);
                        gap_d   = GAP_EN && (rem_q != LEN_W'(1));
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        // A pop in the same cycle frees a slot, so a full FIFO still accepts the write.
        push     = wr_en && (!full_w || pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rem_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            start_q  <= 1'b0;
            valid_q  <= 1'b0;
            data_q   <= 8'h00;
            gap_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rem_q    <= rem_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            start_q  <= start_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            gap_q    <= gap_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    assign full  = full_w;
    assign count = count_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign start = start_q;
    assign valid = valid_q;
    assign data  = data_q;
endmodule

// File: tb/tb_mands_frame_tx.sv
// Self-checking bench for mands_frame_tx: table of frames plus hand-written corner sequences,
// with a sample queue scoreboard checking every valid beat.
module tb_mands_frame_tx;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset, wr_en, send;
    logic [7:0] wr_data;
    logic [4:0] frame_len;
    logic       full, busy, done, start, valid;
    logic [4:0] count;
    logic [7:0] data;

    int checks = 0;
    int failures = 0;
    int overlap_err = 0;
    int idle_data_err = 0;
    logic [7:0] model_q[$];
    logic [7:0] exp_b;

    typedef struct {
        int          npush;
        logic [31:0] s;
        logic [4:0]  flen;
        int          exp_nv;
        int          exp_cnt;
        int          exp_sum;
        int          exp_max;
    } vec_t;
    vec_t vecs[6];

    mands_frame_tx dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .full(full),
        .count(count), .send(send), .frame_len(frame_len), .busy(busy), .done(done),
        .start(start), .valid(valid), .data(data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, $signed(actual), $signed(expected));
        end
    endtask

    function automatic int exp_lat(input int len);
`ifdef MANDS_TX_GAP_EN
        return (len == 0) ? 2 : 1 + 2 * len;
`else
        return 2 + len;
`endif
    endfunction

    // Scoreboard: every valid beat must match the oldest sample accepted by the FIFO.
    always @(negedge clk) begin
        if (!reset) begin
            if (start && valid) overlap_err++;
            if (!valid && data != 8'h00) idle_data_err++;
            if (valid) begin
                if (model_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL stream_unexpected actual=%02h required=no_sample", data);
                end else begin
                    exp_b = model_q.pop_front();
                    check("stream_data", {24'h0, data}, {24'h0, exp_b});
                end
            end
        end
    end

    task automatic push(input logic [7:0] v);
        wr_en = 1'b1;
        wr_data = v;
        if (model_q.size() < DEPTH) model_q.push_back(v);
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic run_frame(input string name, input logic [4:0] flen, input int push_at,
                             input logic [7:0] push_val, input int resend_at, input int exp_nv,
                             input int exp_cnt, input int exp_sum, input int exp_max, input int lat);
        int cyc, nv, busy_low, sum, mx, v, len;
        len = (flen > 5'd16) ? 16 : int'(flen);
        if (lat < 0) lat = exp_lat(len);
        send = 1'b1;
        frame_len = flen;
        @(posedge clk); #1;
        send = 1'b0;
        check({name, "_start"}, {31'h0, start}, 32'd1);
        check({name, "_start_busy"}, {31'h0, busy}, 32'd1);
        cyc = 1; nv = 0; busy_low = 0; sum = 0; mx = -128;
        while (!done && cyc < 300) begin
            if (cyc == push_at) begin
                wr_en = 1'b1;
                wr_data = push_val;
                model_q.push_back(push_val);
            end
            if (cyc == resend_at) begin
                send = 1'b1;
                frame_len = 5'd4;
            end
            @(posedge clk); #1;
            wr_en = 1'b0;
            send = 1'b0;
            cyc++;
            if (!busy) busy_low++;
            if (valid) begin
                nv++;
                v = int'($signed(data));
                sum += v;
                if (v > mx) mx = v;
            end
        end
        check({name, "_done_seen"}, {31'h0, done}, 32'd1);
        check({name, "_done_latency"}, cyc, lat);
        check({name, "_valid_beats"}, nv, exp_nv);
        check({name, "_busy_low_cycles"}, busy_low, 0);
        check({name, "_sum"}, sum, exp_sum);
        check({name, "_max"}, mx, exp_max);
        @(posedge clk); #1;
        check({name, "_busy_after"}, {30'h0, busy, done}, 32'd0);
        check({name, "_count_after"}, {27'h0, count}, exp_cnt);
        @(posedge clk); #1;
        check({name, "_no_restart"}, {30'h0, start, busy}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout actual=running required=finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        vecs[0] = '{4, {8'h80, 8'h7F, 8'hFD, 8'h05}, 5'd4, 4, 0, 1, 127};
        vecs[1] = '{2, {16'h0, 8'h22, 8'h11}, 5'd1, 1, 1, 17, 17};
        vecs[2] = '{0, 32'h0, 5'd1, 1, 0, 34, 34};
        vecs[3] = '{0, 32'h0, 5'd0, 0, 0, 0, -128};
        vecs[4] = '{3, {8'h0, 8'h03, 8'h02, 8'h01}, 5'd0, 0, 3, 0, -128};
        vecs[5] = '{1, {24'h0, 8'h04}, 5'd4, 4, 0, 10, 4};

        reset = 1'b1; wr_en = 1'b0; send = 1'b0; wr_data = 8'h00; frame_len = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_stream", {22'h0, start, valid, data}, 32'd0);
        check("reset_ctrl", {29'h0, busy, done, full}, 32'd0);
        check("reset_count", {27'h0, count}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < vecs[i].npush; k++) push(vecs[i].s[k*8 +: 8]);
            run_frame($sformatf("vec%0d", i), vecs[i].flen, -1, 8'h00, -1, vecs[i].exp_nv,
                      vecs[i].exp_cnt, vecs[i].exp_sum, vecs[i].exp_max, -1);
        end

        // Underrun: FIFO runs dry mid-frame, refilled five cycles after send.
        push(8'h11);
        push(8'h22);
        run_frame("underrun", 5'd3, 5, 8'h10, -1, 3, 0, 67, 34, 8);

        // Clamp: a 20-sample request becomes 16 beats of -128.
        for (int i = 0; i < 16; i++) push(8'h80);
        run_frame("clamp", 5'd20, -1, 8'h00, -1, 16, 0, -2048, -128, -1);

        // FIFO boundaries: 17th push dropped, then push+pop while full.
        for (int i = 0; i < 17; i++) begin
            push(8'(8'h20 + i));
            if (i == 14) check("not_full_at_15", {31'h0, full}, 32'd0);
            if (i == 15) check("full_at_16", {31'h0, full}, 32'd1);
        end
        check("count_after_17", {27'h0, count}, 32'd16);
        run_frame("full_pushpop", 5'd1, 1, 8'h55, -1, 1, 16, 32, 32, -1);
        run_frame("drain", 5'd16, -1, 8'h00, -1, 16, 0, 685, 85, -1);

        // Second send during a frame must be ignored.
        push(8'h31);
        push(8'h32);
        run_frame("resend", 5'd2, -1, 8'h00, 2, 2, 0, 99, 50, -1);

        // Reset asserted during the second valid beat.
        push(8'hA1); push(8'hA2); push(8'hA3);
        send = 1'b1; frame_len = 5'd3;
        @(posedge clk); #1;
        send = 1'b0;
        begin
            int nv = 0;
            int guard = 0;
            while (nv < 2 && guard < 50) begin
                @(posedge clk); #1;
                guard++;
                if (valid) nv++;
            end
            check("midreset_reached_beat2", nv, 2);
        end
        reset = 1'b1;
        #1;
        check("midreset_stream", {22'h0, start, valid, data}, 32'd0);
        check("midreset_ctrl", {29'h0, busy, done, full}, 32'd0);
        check("midreset_count", {27'h0, count}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        model_q.delete();
        @(posedge clk); #1;
        push(8'h40);
        push(8'hC0);
        run_frame("post_reset", 5'd2, -1, 8'h00, -1, 2, 0, 0, 64, -1);

        check("start_valid_overlap", overlap_err, 0);
        check("data_nonzero_when_invalid", idle_data_err, 0);
        check("scoreboard_leftover", model_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
